// File: rtl/sync_fifo_flags_if.sv
// Bus bundle for sync_fifo_flags: producer/consumer request lines plus every status output.
// Handshake: push_i writes only when accepted (not full, or a pop is accepted in the same cycle);
// pop_i is honoured only while not empty, and pop_valid_o qualifies pop_data_o.
interface sync_fifo_flags_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              push_i;
  logic [DATA_W-1:0] push_data_i;
  logic              pop_i;
  logic              clr_err_i;
  logic [DATA_W-1:0] pop_data_o;
  logic              pop_valid_o;
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;
  logic              underflow_o;

  modport master (
    output push_i, push_data_i, pop_i, clr_err_i,
    input  pop_data_o, pop_valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );

  modport slave (
    input  push_i, push_data_i, pop_i, clr_err_i,
    output pop_data_o, pop_valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with arbitrary depth, registered or fall-through read, threshold flags,
// occupancy count and sticky overflow/underflow error flags.
module sync_fifo_flags #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input logic               clk,
  input logic               reset_n,
  sync_fifo_flags_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_unf;

  logic              w_empty;
  logic              w_full;
  logic              w_pop_acc;
  logic              w_push_acc;
  logic [CNT_W-1:0]  w_count_next;

  // Accept decisions use pre-edge occupancy; a push into a full FIFO rides on a same-cycle pop.
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == C_DEPTH);
  assign w_pop_acc    = bus.pop_i & ~w_empty;
  assign w_push_acc   = bus.push_i & (~w_full | w_pop_acc);
  assign w_count_next = r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop_acc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_push_acc) r_wp <= (r_wp == C_LAST) ? '0 : r_wp + 1'b1;
      if (w_pop_acc)  r_rp <= (r_rp == C_LAST) ? '0 : r_rp + 1'b1;
      r_ovf <= (bus.push_i & ~w_push_acc) | (r_ovf & ~bus.clr_err_i);
      r_unf <= (bus.pop_i & ~w_pop_acc) | (r_unf & ~bus.clr_err_i);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[r_wp] <= bus.push_data_i;
  end

  assign bus.count_o        = r_count;
  assign bus.empty_o        = w_empty;
  assign bus.full_o         = w_full;
  assign bus.almost_full_o  = (r_count >= C_AF);
  assign bus.almost_empty_o = (r_count <= C_AE);
  assign bus.overflow_o     = r_ovf;
  assign bus.underflow_o    = r_unf;

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_W-1:0] r_pop_data;
      logic              r_pop_valid;

      // Data register holds its last word between pops.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_pop_data  <= '0;
          r_pop_valid <= 1'b0;
        end else begin
          r_pop_valid <= w_pop_acc;
          if (w_pop_acc) r_pop_data <= r_mem[r_rp];
        end
      end

      assign bus.pop_data_o  = r_pop_data;
      assign bus.pop_valid_o = r_pop_valid;
    end else begin : g_fwft_read
      // Head word shown directly; forced to zero while empty so unreset storage never leaks.
      assign bus.pop_data_o  = w_empty ? '0 : r_mem[r_rp];
      assign bus.pop_valid_o = ~w_empty;
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a DEPTH=5 registered-read instance and a DEPTH=5
// fall-through instance driven through their bus interfaces.
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DEPTH(5), .DATA_W(8)) bus_a ();
  sync_fifo_flags_if #(.DEPTH(5), .DATA_W(8)) bus_b ();

  sync_fifo_flags #(.DEPTH(5), .DATA_W(8), .FWFT(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );
  sync_fifo_flags #(.DEPTH(5), .DATA_W(8), .FWFT(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic push, input logic [7:0] data, input logic pop, input logic clr);
    bus_a.push_i      = push;
    bus_a.push_data_i = data;
    bus_a.pop_i       = pop;
    bus_a.clr_err_i   = clr;
  endtask

  task automatic drive_b(input logic push, input logic [7:0] data, input logic pop);
    bus_b.push_i      = push;
    bus_b.push_data_i = data;
    bus_b.pop_i       = pop;
    bus_b.clr_err_i   = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_count"}, bus_a.count_o, 0);
    chk({tag, "_empty"}, bus_a.empty_o, 1);
    chk({tag, "_full"}, bus_a.full_o, 0);
    chk({tag, "_ae"}, bus_a.almost_empty_o, 1);
    chk({tag, "_af"}, bus_a.almost_full_o, 0);
    chk({tag, "_valid"}, bus_a.pop_valid_o, 0);
    chk({tag, "_data"}, bus_a.pop_data_o, 0);
    chk({tag, "_ovf"}, bus_a.overflow_o, 0);
    chk({tag, "_unf"}, bus_a.underflow_o, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    drive_b(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    chk_reset_a("rst");
    chk("rst_b_valid", bus_b.pop_valid_o, 0);
    chk("rst_b_data", bus_b.pop_data_o, 0);
    #2 reset_n = 1'b1;

    // Test 1: fill to full, then drain with one-cycle read latency.
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
      tick();
      chk("t1_count", bus_a.count_o, i + 1);
      chk("t1_af", bus_a.almost_full_o, (i + 1) >= 4);
      chk("t1_ae", bus_a.almost_empty_o, (i + 1) <= 1);
      chk("t1_full", bus_a.full_o, (i + 1) == 5);
      chk("t1_empty", bus_a.empty_o, 0);
    end
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      chk("t1_pop_data", bus_a.pop_data_o, 8'h11 + i);
      chk("t1_pop_valid", bus_a.pop_valid_o, 1);
      chk("t1_pop_count", bus_a.count_o, 4 - i);
    end
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("t1_idle_valid", bus_a.pop_valid_o, 0);
    chk("t1_idle_hold", bus_a.pop_data_o, 8'h15);
    chk("t1_idle_empty", bus_a.empty_o, 1);

    // Test 2: interleaved push/pop of 12 words, pointers wrap twice.
    for (int k = 0; k <= 12; k++) begin
      drive_a(k < 12, 8'(8'h20 + k), k >= 1, 1'b0);
      tick();
      chk("t2_valid", bus_a.pop_valid_o, k >= 1);
      if (k >= 1) chk("t2_data", bus_a.pop_data_o, 8'h20 + k - 1);
      chk("t2_count", bus_a.count_o, (k < 12) ? 1 : 0);
    end
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);

    // Test 3: push and pop together while full.
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, 8'(8'h01 + i), 1'b0, 1'b0);
      exp_q.push_back(8'(8'h01 + i));
      tick();
    end
    chk("t3_full", bus_a.full_o, 1);
    drive_a(1'b1, 8'hAA, 1'b1, 1'b0);
    exp_q.push_back(8'hAA);
    tick();
    exp_w = exp_q.pop_front();
    chk("t3_pp_data", bus_a.pop_data_o, exp_w);
    chk("t3_pp_count", bus_a.count_o, 5);
    chk("t3_pp_full", bus_a.full_o, 1);
    chk("t3_pp_ovf", bus_a.overflow_o, 0);
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      exp_w = exp_q.pop_front();
      chk("t3_drain", bus_a.pop_data_o, exp_w);
    end
    chk("t3_last", bus_a.pop_data_o, 8'hAA);
    chk("t3_empty", bus_a.empty_o, 1);
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);

    // Test 4: overflow, underflow, clear, set-wins and push+pop on empty.
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
      exp_q.push_back(8'(8'h61 + i));
      tick();
    end
    drive_a(1'b1, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("t4_ovf", bus_a.overflow_o, 1);
    chk("t4_ovf_count", bus_a.count_o, 5);
    chk("t4_ovf_unf", bus_a.underflow_o, 0);
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      exp_w = exp_q.pop_front();
      chk("t4_drain", bus_a.pop_data_o, exp_w);
    end
    tick();
    chk("t4_unf", bus_a.underflow_o, 1);
    chk("t4_unf_valid", bus_a.pop_valid_o, 0);
    chk("t4_unf_count", bus_a.count_o, 0);
    chk("t4_ovf_sticky", bus_a.overflow_o, 1);
    drive_a(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("t4_clr_ovf", bus_a.overflow_o, 0);
    chk("t4_clr_unf", bus_a.underflow_o, 0);
    drive_a(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    chk("t4_set_wins", bus_a.underflow_o, 1);
    drive_a(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("t4_clr2_unf", bus_a.underflow_o, 0);
    drive_a(1'b1, 8'h99, 1'b1, 1'b0);
    tick();
    chk("t4_pe_count", bus_a.count_o, 1);
    chk("t4_pe_unf", bus_a.underflow_o, 1);
    chk("t4_pe_valid", bus_a.pop_valid_o, 0);
    drive_a(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk("t4_pe_data", bus_a.pop_data_o, 8'h99);
    chk("t4_pe_valid2", bus_a.pop_valid_o, 1);
    chk("t4_pe_count2", bus_a.count_o, 0);
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);

    // Test 5: fall-through instance.
    chk("t5_init_valid", bus_b.pop_valid_o, 0);
    chk("t5_init_empty", bus_b.empty_o, 1);
    drive_b(1'b1, 8'h3C, 1'b0);
    tick();
    chk("t5_ft_valid", bus_b.pop_valid_o, 1);
    chk("t5_ft_data", bus_b.pop_data_o, 8'h3C);
    chk("t5_ft_count", bus_b.count_o, 1);
    drive_b(1'b1, 8'h3D, 1'b0);
    tick();
    chk("t5_head_hold", bus_b.pop_data_o, 8'h3C);
    chk("t5_count2", bus_b.count_o, 2);
    drive_b(1'b0, 8'h00, 1'b1);
    tick();
    chk("t5_next_data", bus_b.pop_data_o, 8'h3D);
    chk("t5_next_valid", bus_b.pop_valid_o, 1);
    tick();
    chk("t5_end_empty", bus_b.empty_o, 1);
    chk("t5_end_valid", bus_b.pop_valid_o, 0);
    drive_b(1'b0, 8'h00, 1'b0);

    // Test 6: asynchronous reset with entries held and an error flag set.
    drive_a(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
      tick();
    end
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_pre_count", bus_a.count_o, 3);
    chk("t6_pre_unf", bus_a.underflow_o, 1);
    #3 reset_n = 1'b0;
    #1;
    chk_reset_a("t6_async");
    tick();
    tick();
    #2 reset_n = 1'b1;
    drive_a(1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    chk("t6_push_count", bus_a.count_o, 1);
    drive_a(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk("t6_pop_data", bus_a.pop_data_o, 8'h77);
    chk("t6_pop_valid", bus_a.pop_valid_o, 1);
    chk("t6_pop_count", bus_a.count_o, 0);
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("t6_end_empty", bus_a.empty_o, 1);
    chk("t6_end_valid", bus_a.pop_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parameterised single-clock FIFO, successor to the basic push/pop FIFO. Adds:
- non-power-of-two depth
- selectable read mode: registered or first-word-fall-through
- programmable almost-full/almost-empty thresholds
- an occupancy count
- sticky overflow/underflow error flags

It is the general-purpose buffer between producer/consumer pipeline stages in one clock domain.

Parameters:
DEPTH, 4, number of entries; any integer >= 2 (power of two not required)
DATA_W, 8, data width in bits
FWFT, 0, 0 = registered read (data one cycle after pop); 1 = first-word-fall-through
AF_LEVEL, DEPTH-1, almost_full_o asserts when count >= AF_LEVEL; legal 1..DEPTH
AE_LEVEL, 1, almost_empty_o asserts when count <= AE_LEVEL; legal 0..DEPTH-1

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
push_i  input  1  write request
push_data_i  input  DATA_W  write data
pop_i  input  1  read request
pop_data_o  output  DATA_W  read data
pop_valid_o  output  1  pop_data_o valid qualifier
full_o  output  1  count == DEPTH
empty_o  output  1  count == 0
almost_full_o  output  1  count >= AF_LEVEL
almost_empty_o  output  1  count <= AE_LEVEL
count_o  output  $clog2(DEPTH+1)  current occupancy
overflow_o  output  1  sticky: push dropped while full
underflow_o  output  1  sticky: pop ignored while empty
clr_err_i  input  1  synchronous clear of overflow_o/underflow_o

Behaviour:
- Reset (reset_n low, async, takes effect immediately):
  - wp = rp = 0; count_o = 0; empty_o = 1; full_o = 0
  - almost_empty_o = 1; almost_full_o = (AF_LEVEL == 0 ? 1 : 0), i.e. 0 for legal AF_LEVEL
  - pop_data_o = 0; pop_valid_o = 0; overflow_o = underflow_o = 0
  - Storage contents are not reset.
  - Reset mid-operation discards all entries; the first push after release lands at index 0.
- Pointers:
  - wp/rp range 0..DEPTH-1; wrap from DEPTH-1 to 0 (explicit compare, not power-of-two rollover).
  - Occupancy is held in a separate count register.
- Accept rules, evaluated on pre-edge state:
  - pop_acc = pop_i & ~empty_o
  - push_acc = push_i & (~full_o | pop_acc)
  - Push while full is accepted only when a pop is accepted in the same cycle; count is unchanged.
  - Push and pop while empty: push accepted, pop rejected, underflow_o set. The pushed word appears per the mode rules next cycle.
  - count_next = count + push_acc - pop_acc.
- Flags:
  - full/empty/almost flags and count_o are registered, or decoded purely from registered count.
  - They reflect the post-edge count the cycle after the update.
- Errors:
  - overflow_o sets on push_i & ~push_acc; underflow_o sets on pop_i & ~pop_acc.
  - Both stay set until clr_err_i.
  - If clr_err_i and a new error occur in the same cycle, set wins.
- FWFT = 0:
  - On pop_acc, pop_data_o <= mem[rp] and pop_valid_o = 1 the next cycle (latency 1).
  - Without pop_acc, pop_valid_o = 0 and pop_data_o holds its last value (it is not zeroed).
- FWFT = 1:
  - pop_data_o = mem[rp] combinationally; pop_valid_o = ~empty_o.
  - pop_i acknowledges the current word; the next word is presented the following cycle.
  - A word pushed into an empty FIFO is visible on pop_data_o the cycle after the push edge.
- Ordering is strict FIFO in all cases, including across wrap.

Test Plan:
1. DEPTH=5, DATA_W=8, FWFT=0: push 0x11..0x15 on 5 consecutive cycles -> full_o=1, count_o=5, almost_full_o from count 4. Then pop 5 cycles -> pop_data_o = 0x11..0x15 one cycle after each pop, pop_valid_o high 5 cycles, empty_o=1 at end.
2. Wrap: DEPTH=5; push/pop interleaved for 12 words 0x20..0x2B -> output order preserved across two pointer wraps at index 4 -> 0; count_o never exceeds 2.
3. Full + simultaneous push/pop: fill 0x01..0x05, then push 0xAA with pop in the same cycle -> 0x01 read out, count_o stays 5, overflow_o=0. After draining, the sequence ends 0x05, 0xAA.
4. Errors: push 0xFF while full without pop -> overflow_o=1 and 0xFF never appears. Pop on empty -> underflow_o=1. clr_err_i pulse -> both 0 the next cycle.
5. FWFT=1: push 0x3C into empty FIFO -> next cycle pop_valid_o=1, pop_data_o=0x3C with no pop issued. Pop -> empty_o=1, pop_valid_o=0 next cycle.
6. Reset mid-operation: 3 entries held, reset_n low asynchronously between edges -> outputs reach reset values immediately. After release, push 0x77 then pop -> 0x77 returned; old entries never appear.
